// File: rtl/load_queue_fu.sv
// load_queue_fu: multi-entry in-order load unit between the load issue port
// and the CDB arbiter. Entries are allocated at tail, sent to the single data
// memory port at mptr, and retired at head once the CDB acknowledges them.
// Optional feature macro: LOAD_FU_MISALIGN_CHECK_EN (misaligned loads skip
// memory and complete with out_exc set).
module load_queue_fu #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned XLEN  = 32,
    parameter int unsigned TAG_W = 5
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             issue_valid,
    output logic             issue_ready,
    input  logic [XLEN-1:0]  issue_rs1,
    input  logic [XLEN-1:0]  issue_imm,
    input  logic [2:0]       issue_funct3,
    input  logic [TAG_W-1:0] issue_rob_tag,
    input  logic             flush,
    output logic             mem_req,
    output logic [XLEN-1:0]  mem_addr,
    output logic [1:0]       mem_size,
    input  logic             mem_ack,
    input  logic [XLEN-1:0]  mem_rdata,
    output logic             out_valid,
    output logic [TAG_W-1:0] out_rob_tag,
    output logic [XLEN-1:0]  out_value,
    output logic             out_exc,
    input  logic             out_ack
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    typedef enum logic [1:0] {
        FREE     = 2'd0,
        WAIT_MEM = 2'd1,
        DONE     = 2'd2
    } entry_state_e;

    entry_state_e     state_q  [DEPTH];
    logic [TAG_W-1:0] tag_q    [DEPTH];
    logic [XLEN-1:0]  addr_q   [DEPTH];
    logic [XLEN-1:0]  data_q   [DEPTH];
    logic [2:0]       funct3_q [DEPTH];
`ifdef LOAD_FU_MISALIGN_CHECK_EN
    logic             mis_q    [DEPTH];
    logic             exc_q    [DEPTH];
`endif

    logic [PTR_W-1:0] tail_q, mptr_q, head_q;
    logic [CNT_W-1:0] count_q;

    logic            accept;
    logic            wb_fire;
    logic            mem_fire;
    logic            mptr_skip;
    logic            mptr_waiting;
    logic [XLEN-1:0] issue_addr;

    // Sign/zero extension of returned memory data by load size
    function automatic logic [XLEN-1:0] extend(input logic [2:0] f3, input logic [XLEN-1:0] d);
        case (f3[1:0])
            2'd0:    extend = f3[2] ? XLEN'(d[7:0])  : {{(XLEN-8){d[7]}}, d[7:0]};
            2'd1:    extend = f3[2] ? XLEN'(d[15:0]) : {{(XLEN-16){d[15]}}, d[15:0]};
            default: extend = d;
        endcase
    endfunction

`ifdef LOAD_FU_MISALIGN_CHECK_EN
    // Half loads need 2-byte alignment, word loads 4-byte alignment
    function automatic logic misaligned(input logic [2:0] f3, input logic [XLEN-1:0] a);
        misaligned = ((f3[1:0] == 2'd1) && a[0]) ||
                     ((f3[1:0] == 2'd2) && (a[1:0] != 2'd0));
    endfunction
`endif

    // Handshakes and memory-port view of the entry at mptr
    always_comb begin
        issue_addr   = issue_rs1 + issue_imm;
        issue_ready  = (count_q != CNT_W'(DEPTH));
        accept       = issue_valid && issue_ready;
        mptr_waiting = (state_q[mptr_q] == WAIT_MEM);
`ifdef LOAD_FU_MISALIGN_CHECK_EN
        mptr_skip    = mptr_waiting && mis_q[mptr_q];
`else
        mptr_skip    = 1'b0;
`endif
        mem_req      = mptr_waiting && !mptr_skip;
        mem_addr     = addr_q[mptr_q];
        mem_size     = funct3_q[mptr_q][1:0];
        mem_fire     = mem_req && mem_ack;
        out_valid    = (state_q[head_q] == DONE);
        out_rob_tag  = tag_q[head_q];
        out_value    = data_q[head_q];
`ifdef LOAD_FU_MISALIGN_CHECK_EN
        out_exc      = exc_q[head_q];
`else
        out_exc      = 1'b0;
`endif
        wb_fire      = out_valid && out_ack;
    end

    // Entry storage, pointers and occupancy; flush overrides every other update
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                state_q[i]  <= FREE;
                tag_q[i]    <= '0;
                addr_q[i]   <= '0;
                data_q[i]   <= '0;
                funct3_q[i] <= '0;
`ifdef LOAD_FU_MISALIGN_CHECK_EN
                mis_q[i]    <= 1'b0;
                exc_q[i]    <= 1'b0;
`endif
            end
            tail_q  <= '0;
            mptr_q  <= '0;
            head_q  <= '0;
            count_q <= '0;
        end else if (flush) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                state_q[i] <= FREE;
            end
            tail_q  <= '0;
            mptr_q  <= '0;
            head_q  <= '0;
            count_q <= '0;
        end else begin
            if (accept) begin
                state_q[tail_q]  <= WAIT_MEM;
                tag_q[tail_q]    <= issue_rob_tag;
                addr_q[tail_q]   <= issue_addr;
                funct3_q[tail_q] <= issue_funct3;
`ifdef LOAD_FU_MISALIGN_CHECK_EN
                mis_q[tail_q]    <= misaligned(issue_funct3, issue_addr);
                exc_q[tail_q]    <= 1'b0;
`endif
                tail_q <= tail_q + PTR_W'(1);
            end
            if (mem_fire) begin
                state_q[mptr_q] <= DONE;
                data_q[mptr_q]  <= extend(funct3_q[mptr_q], mem_rdata);
                mptr_q          <= mptr_q + PTR_W'(1);
            end
`ifdef LOAD_FU_MISALIGN_CHECK_EN
            if (mptr_skip) begin
                state_q[mptr_q] <= DONE;
                data_q[mptr_q]  <= '0;
                exc_q[mptr_q]   <= 1'b1;
                mptr_q          <= mptr_q + PTR_W'(1);
            end
`endif
            if (wb_fire) begin
                state_q[head_q] <= FREE;
                head_q          <= head_q + PTR_W'(1);
            end
            if (accept && !wb_fire) begin
                count_q <= count_q + CNT_W'(1);
            end else if (!accept && wb_fire) begin
                count_q <= count_q - CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_load_queue_fu.sv
// tb_load_queue_fu: randomized and directed bench for load_queue_fu with an
// in-order queue reference model (LOAD_FU_MISALIGN_CHECK_EN aware).
module tb_load_queue_fu;

    localparam int unsigned DEPTH = 4;

    logic        clock = 1'b0;
    logic        reset;
    logic        issue_valid;
    logic        issue_ready;
    logic [31:0] issue_rs1;
    logic [31:0] issue_imm;
    logic [2:0]  issue_funct3;
    logic [4:0]  issue_rob_tag;
    logic        flush;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic [1:0]  mem_size;
    logic        mem_ack;
    logic [31:0] mem_rdata;
    logic        out_valid;
    logic [4:0]  out_rob_tag;
    logic [31:0] out_value;
    logic        out_exc;
    logic        out_ack;

    load_queue_fu #(.DEPTH(DEPTH), .XLEN(32), .TAG_W(5)) dut (
        .clock(clock), .reset(reset),
        .issue_valid(issue_valid), .issue_ready(issue_ready),
        .issue_rs1(issue_rs1), .issue_imm(issue_imm),
        .issue_funct3(issue_funct3), .issue_rob_tag(issue_rob_tag),
        .flush(flush),
        .mem_req(mem_req), .mem_addr(mem_addr), .mem_size(mem_size),
        .mem_ack(mem_ack), .mem_rdata(mem_rdata),
        .out_valid(out_valid), .out_rob_tag(out_rob_tag),
        .out_value(out_value), .out_exc(out_exc), .out_ack(out_ack)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [4:0]  tag;
        logic [31:0] addr;
        logic [2:0]  f3;
        bit          mis;
        bit          done;
        bit          exc;
        logic [31:0] value;
    } ld_t;

    ld_t q[$];
    int  n_checks = 0;
    int  n_fail   = 0;
    bit  started  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference load extension: take the low bytes, then subtract 2^bits if signed and negative
    function automatic logic [31:0] ref_ext(input logic [2:0] f3, input logic [31:0] d);
        logic [31:0] v;
        if (f3[1:0] == 2'd0) begin
            v = d & 32'hFF;
            if (!f3[2] && v >= 32'h80) v = v - 32'h100;
        end else if (f3[1:0] == 2'd1) begin
            v = d & 32'hFFFF;
            if (!f3[2] && v >= 32'h8000) v = v - 32'h10000;
        end else begin
            v = d;
        end
        return v;
    endfunction

    function automatic bit ref_mis(input logic [2:0] f3, input logic [31:0] a);
`ifdef LOAD_FU_MISALIGN_CHECK_EN
        return (f3[1:0] == 2'd1 && (a % 2) != 0) || (f3[1:0] == 2'd2 && (a % 4) != 0);
`else
        return 1'b0;
`endif
    endfunction

    function automatic int first_pending();
        for (int i = 0; i < q.size(); i++) if (!q[i].done) return i;
        return q.size();
    endfunction

    // Reference model: advance the in-order queue at each clock edge
    always @(posedge clock) begin
        int  sz;
        int  m;
        bit  ov;
        ld_t e;
        if (reset) started = 1;
        if (reset || flush) begin
            q.delete();
        end else begin
            sz = q.size();
            ov = (sz > 0) && q[0].done;
            m  = first_pending();
            if (m < sz) begin
                e = q[m];
                if (e.mis) begin
                    e.done = 1; e.exc = 1; e.value = 32'h0;
                end else if (mem_ack) begin
                    e.done = 1; e.value = ref_ext(e.f3, mem_rdata);
                end
                q[m] = e;
            end
            if (ov && out_ack) void'(q.pop_front());
            if (issue_valid && sz < DEPTH) begin
                e.tag = issue_rob_tag; e.addr = issue_rs1 + issue_imm; e.f3 = issue_funct3;
                e.mis = ref_mis(issue_funct3, issue_rs1 + issue_imm);
                e.done = 0; e.exc = 0; e.value = 32'h0;
                q.push_back(e);
            end
        end
    end

    // Compare DUT outputs with the model every cycle
    always @(negedge clock) begin
        int m;
        bit exp_req;
        bit exp_ov;
        if (started) begin
            m       = first_pending();
            exp_req = (m < q.size()) && !q[m].mis;
            exp_ov  = (q.size() > 0) && q[0].done;
            chk("m_issue_ready", 32'(issue_ready), 32'(q.size() < DEPTH));
            chk("m_mem_req", 32'(mem_req), 32'(exp_req));
            if (exp_req) begin
                chk("m_mem_addr", mem_addr, q[m].addr);
                chk("m_mem_size", 32'(mem_size), 32'(q[m].f3[1:0]));
            end
            chk("m_out_valid", 32'(out_valid), 32'(exp_ov));
            if (exp_ov) begin
                chk("m_out_tag", 32'(out_rob_tag), 32'(q[0].tag));
                chk("m_out_value", out_value, q[0].value);
                chk("m_out_exc", 32'(out_exc), 32'(q[0].exc));
            end
        end
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic issue(input logic [31:0] rs1, input logic [31:0] imm,
                         input logic [2:0] f3, input logic [4:0] tag);
        issue_valid = 1; issue_rs1 = rs1; issue_imm = imm; issue_funct3 = f3; issue_rob_tag = tag;
    endtask

    logic [2:0] f3_pool [5] = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
    logic [4:0] next_tag = 5'd0;

    initial begin
        reset = 1; issue_valid = 0; issue_rs1 = 0; issue_imm = 0; issue_funct3 = 0;
        issue_rob_tag = 0; flush = 0; mem_ack = 0; mem_rdata = 0; out_ack = 0;
        step(); step();
        reset = 0;
        chk("rst_issue_ready", 32'(issue_ready), 32'd1);
        chk("rst_mem_req", 32'(mem_req), 32'd0);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_mem_addr", mem_addr, 32'd0);
        chk("rst_mem_size", 32'(mem_size), 32'd0);
        chk("rst_out_tag", 32'(out_rob_tag), 32'd0);
        chk("rst_out_value", out_value, 32'd0);
        chk("rst_out_exc", 32'(out_exc), 32'd0);

        // Signed byte load
        issue(32'h1000, 32'h4, 3'd0, 5'd3);
        step();
        issue_valid = 0;
        chk("sb_mem_req", 32'(mem_req), 32'd1);
        chk("sb_mem_addr", mem_addr, 32'h1004);
        chk("sb_mem_size", 32'(mem_size), 32'd0);
        mem_ack = 1; mem_rdata = 32'h000000F0;
        step();
        mem_ack = 0;
        chk("sb_out_valid", 32'(out_valid), 32'd1);
        chk("sb_out_tag", 32'(out_rob_tag), 32'd3);
        chk("sb_out_value", out_value, 32'hFFFFFFF0);
        out_ack = 1;
        step();
        out_ack = 0;
        chk("sb_retired", 32'(out_valid), 32'd0);

        // Unsigned half load
        issue(32'h2000, 32'h2, 3'd5, 5'd4);
        step();
        issue_valid = 0;
        chk("uh_mem_size", 32'(mem_size), 32'd1);
        mem_ack = 1; mem_rdata = 32'h12348001;
        step();
        mem_ack = 0;
        chk("uh_out_value", out_value, 32'h00008001);
        out_ack = 1;
        step();
        out_ack = 0;

        // Fill the queue with memory always acking and no writeback
        mem_ack = 1;
        for (int k = 0; k < 4; k++) begin
            mem_rdata = $urandom;
            issue(32'h3000 + 32'(4 * k), 32'h0, 3'd2, 5'(10 + k));
            step();
        end
        issue_valid = 0;
        chk("fill_ready_low", 32'(issue_ready), 32'd0);
        step(); step(); step();
        chk("fill_mem_idle", 32'(mem_req), 32'd0);
        mem_ack = 0;
        for (int k = 0; k < 4; k++) begin
            chk("fill_out_valid", 32'(out_valid), 32'd1);
            chk("fill_out_tag", 32'(out_rob_tag), 32'(10 + k));
            out_ack = 1;
            step();
            out_ack = 0;
            if (k == 0) chk("fill_ready_back", 32'(issue_ready), 32'd1);
        end

        // Flush with pending loads and a coincident memory ack
        for (int k = 0; k < 3; k++) begin
            issue(32'h4000, 32'(4 * k), 3'd2, 5'(20 + k));
            step();
        end
        issue_valid = 0;
        chk("fl_pre_req", 32'(mem_req), 32'd1);
        mem_ack = 1; mem_rdata = 32'hDEADBEEF; flush = 1;
        step();
        flush = 0;
        chk("fl_out_valid", 32'(out_valid), 32'd0);
        chk("fl_mem_req", 32'(mem_req), 32'd0);
        chk("fl_issue_ready", 32'(issue_ready), 32'd1);
        for (int k = 0; k < 4; k++) begin
            step();
            chk("fl_no_stale", 32'(out_valid), 32'd0);
        end
        mem_ack = 0;

`ifdef LOAD_FU_MISALIGN_CHECK_EN
        // Misaligned word load skips memory
        issue(32'h1000, 32'h2, 3'd2, 5'd7);
        step();
        issue_valid = 0;
        chk("mis_no_req", 32'(mem_req), 32'd0);
        step();
        chk("mis_out_valid", 32'(out_valid), 32'd1);
        chk("mis_out_exc", 32'(out_exc), 32'd1);
        chk("mis_out_value", out_value, 32'd0);
        out_ack = 1;
        step();
        out_ack = 0;
`endif

        // Randomized traffic with random ack delays, back-pressure and rare flushes
        for (int c = 0; c < 600; c++) begin
            issue_valid   = ($urandom_range(0, 3) != 0);
            issue_rs1     = $urandom;
            issue_imm     = $urandom;
            issue_funct3  = f3_pool[$urandom_range(0, 4)];
            issue_rob_tag = next_tag;
            next_tag      = next_tag + 5'd1;
            mem_ack       = ($urandom_range(0, 2) != 0);
            mem_rdata     = $urandom;
            out_ack       = ($urandom_range(0, 2) != 0);
            flush         = ($urandom_range(0, 63) == 0);
            step();
        end

        // Drain with a bounded wait
        issue_valid = 0; flush = 0; mem_ack = 1; out_ack = 1;
        for (int c = 0; c < 100 && q.size() != 0; c++) begin
            mem_rdata = $urandom;
            step();
        end
        if (q.size() != 0) begin
            n_checks++; n_fail++;
            $display("FAIL drain_timeout: %0d entries left, required 0", q.size());
        end
        mem_ack = 0; out_ack = 0;
        step();
        chk("end_out_valid", 32'(out_valid), 32'd0);
        chk("end_mem_req", 32'(mem_req), 32'd0);
        chk("end_issue_ready", 32'(issue_ready), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/load_queue_fu.md
# load_queue_fu

Parametrised, multi-entry load functional unit for the out-of-order core. Accepts up to DEPTH issued loads, computes each effective address, arbitrates them in program order onto the single data-memory port, then sign- or zero-extends the returned data. It holds completed results until the CDB acknowledges them. It sits between the load reservation-station issue port and the CDB arbiter, and supports multiple in-flight loads, back-pressure and squash.

## Interface
- DEPTH, 4: load entries; power of two, 2..16.
- XLEN, 32: data/address width.
- TAG_W, 5: ROB tag width.
- clock  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- issue_valid  in  1  load presented for acceptance.
- issue_ready  out  1  entry free; the load is accepted when issue_valid && issue_ready.
- issue_rs1  in  XLEN  base register value.
- issue_imm  in  XLEN  sign-extended I-immediate.
- issue_funct3  in  3  load funct3: [1:0] size (0 byte, 1 half, 2 word), [2] unsigned.
- issue_rob_tag  in  TAG_W  destination ROB tag.
- flush  in  1  squash all entries.
- mem_req  out  1  load request to data memory.
- mem_addr  out  XLEN  request address.
- mem_size  out  2  request size (MEM_SIZE encoding).
- mem_ack  in  1  memory accepted the request and returned data this cycle.
- mem_rdata  in  XLEN  returned data, valid when mem_ack.
- out_valid  out  1  oldest completed result available.
- out_rob_tag  out  TAG_W  tag of the result.
- out_value  out  XLEN  extended load data.
- out_exc  out  1  misaligned-access exception (see Configuration).
- out_ack  in  1  CDB consumed the result.

## Operation
- Circular buffer with three pointers: tail (allocate), mptr (next to memory), head (writeback). All are log2(DEPTH) bits and wrap modulo DEPTH. A count register (0..DEPTH) tracks occupancy.
- Each entry holds a state, a tag, an address, funct3, data and exc. State is one of FREE, WAIT_MEM or DONE.
- Accept: the entry at tail gets state WAIT_MEM and addr = rs1 + imm (modulo 2^XLEN, carry discarded). tail increments and count increments.
- Memory: mem_req = (entry[mptr] == WAIT_MEM). mem_addr and mem_size are driven combinationally from that entry.
- On mem_ack while mem_req is high, the entry becomes DONE and data = extend(mem_rdata). mptr increments.
- Memory requests are strictly in order, with at most one outstanding. A request may be withdrawn at any time with no side effect.
- Extension:
  - Byte: bits [XLEN-1:8] are zero (unsigned) or copies of bit 7 (signed).
  - Half: bits [XLEN-1:16] are zero (unsigned) or copies of bit 15 (signed).
  - Word: passed through unchanged.
- Writeback: out_valid = (entry[head] == DONE), with the outputs taken from that entry. On out_ack && out_valid the entry becomes FREE, head increments and count decrements. out_ack while out_valid is low is ignored.
- issue_ready = (count != DEPTH), computed from registered count only. A full queue does not accept in the same cycle as a writeback frees an entry.
- Simultaneous accept and writeback: count is unchanged and both pointers advance.
- Simultaneous mem_ack and out_ack on different entries: both take effect.
- flush: next cycle all entries are FREE and head = tail = mptr = count = 0.
  - flush has priority over accept, mem_ack and out_ack in the same cycle.
  - mem_req is low in the cycle after flush.
  - A mem_ack coinciding with flush is discarded.
- Reset: all entries FREE, all pointers 0 and count 0.
  - issue_ready = 1, mem_req = 0, out_valid = 0.
  - mem_addr, mem_size, out_rob_tag, out_value and out_exc are all 0.

## Timing
- Accept in cycle N: mem_req is high at N+1 at the earliest, if the memory port is idle.
- mem_ack at cycle M: out_valid is high at M+1 if the entry is at head. The minimum issue-to-out_valid latency is 2 cycles with a same-cycle ack.
- out_ack at cycle K: the next entry's result may be presented at K+1.
- Back-to-back loads: one memory completion per cycle is sustainable when memory acks every cycle.

## Configuration
- LOAD_FU_MISALIGN_CHECK_EN defined:
  - At accept, a half load with addr[0] != 0, or a word load with addr[1:0] != 0, is marked misaligned.
  - A misaligned entry skips memory: it goes straight to DONE with exc = 1 and data = 0. mptr steps over it without asserting mem_req.
  - The skip happens when the entry reaches mptr and takes one cycle.
- LOAD_FU_MISALIGN_CHECK_EN undefined: no alignment check is done and all loads go to memory. out_exc is tied to 0.

## Test plan
- Single signed byte: rs1=0x1000, imm=0x4, funct3=0, tag 3; mem_ack with rdata=0x000000F0 -> mem_addr=0x1004, mem_size=BYTE; out_valid with tag 3 and value 0xFFFFFFF0.
- Unsigned half: funct3=5, rdata=0x1234_8001 -> out_value=0x00008001.
- Fill 4 loads with mem_ack tied high and out_ack low -> issue_ready=0 after the 4th accept, mem_req=0 once all are DONE. Then pulse out_ack 4 times -> tags return in issue order and issue_ready=1 after the first ack.
- Wrap-around: stream 10 loads with random ack delays -> results in order, pointers wrap correctly, count never exceeds 4.
- Flush with 3 entries pending and a coincident mem_ack -> next cycle out_valid=0, mem_req=0, issue_ready=1; no stale result appears afterwards.
- With LOAD_FU_MISALIGN_CHECK_EN: word load to 0x1002 -> no mem_req for that entry, out_valid with exc=1 and value 0.
